pci_cfg_master: RTL and testbench
=================================

# pci_cfg_master

Sequencer and arbiter for PCI configuration cycles on the testbench PCI bus model. Accepts config-read/config-write commands from up to NUM_REQ requesters (DPI-driven software tasks, BFMs), picks one by round-robin, drives the FRAME#/IRDY# address and data phases, and returns read data or completion status to the winner. It is the single bus master for config space, so the DPI task layer no longer toggles bus signals directly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 16, DATA-phase cycles without TRDY# before master abort (used only with PCI_CFG_TIMEOUT_EN)
- pci_clk  in  1  bus clock; all logic on rising edge
- pci_rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_cmd  in  2*NUM_REQ  per-requester command: 1 = CFGREAD, 2 = CFGWRITE
- req_addr  in  32*NUM_REQ  per-requester config address
- req_wdata  in  32*NUM_REQ  per-requester write data
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  32  read data (valid with rsp_valid)
- rsp_err  out  1  error flag (valid with rsp_valid)
- pci_frame_n, pci_irdy_n  out  1  bus control, active-low
- pci_trdy_n  in  1  target ready, active-low
- pci_cbe_n  out  4  command/byte enables
- pci_ad_out  out  32  AD drive value
- pci_ad_oe  out  1  AD output enable
- pci_ad_in  in  32  AD sampled value

## Operation
- FSM: IDLE -> ADDR -> DATA -> TURN -> IDLE.
- IDLE: if any req_valid, round-robin grant starting at index ptr+1 (mod NUM_REQ); latch cmd/addr/wdata, pulse req_ready[g] for this cycle. Pointer becomes g.
- ADDR (1 cycle): frame_n=0, irdy_n=1, ad_out=addr, ad_oe=1, cbe_n=4'hA (read) / 4'hB (write).
- DATA: frame_n=1, irdy_n=0, cbe_n=4'h0; write: ad_out=wdata, ad_oe=1; read: ad_oe=0. Stays until pci_trdy_n==0 sampled; read captures pci_ad_in at that edge.
- TURN (1 cycle): irdy_n=1, ad_oe=0; rsp_valid[g]=1, rsp_rdata = captured data (0 for write), rsp_err=0.
- Illegal cmd (0 or 3): accepted in IDLE, no bus cycle; next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, then IDLE.
- Requester must hold req_* stable while req_valid=1 and not accepted; dropping req_valid before accept is legal.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, frame_n=1, irdy_n=1, cbe_n=4'hF, ad_out=0, ad_oe=0, ptr=NUM_REQ-1 (first grant goes to index 0), state IDLE.
- Accept at cycle N; ADDR N+1; DATA N+2; zero-wait TRDY#: TURN/rsp_valid at N+3; IDLE at N+4; next accept earliest N+4. Each TRDY# wait cycle adds one.
- Simultaneous requests: exactly one granted; a requester held valid is served within NUM_REQ transactions.
- pci_trdy_n low during ADDR or IDLE is ignored.
- Reset mid-transaction: next edge all outputs to reset values, no rsp_valid for the aborted command.

## Configuration
- PCI_CFG_TIMEOUT_EN defined: 8-bit wait counter cleared on entering DATA; after TIMEOUT_CYCLES DATA cycles without TRDY#, go to TURN with rsp_err=1, rsp_rdata=32'hFFFF_FFFF (master abort).
- Undefined: no counter; DATA waits indefinitely; rsp_err only for illegal cmd.

## Structure
- Package pci_cfg_pkg: PCI_CFGREAD=1, PCI_CFGWRITE=2, CBE_CFGREAD=4'hA, CBE_CFGWRITE=4'hB, state enum, pci_cfg_cmd_t struct {addr, cmd, wdata}.
- Sub-module pci_cfg_rr_arb: NUM_REQ round-robin arbiter (req vector, advance strobe -> one-hot grant, index).

## Test plan
- Single read, req 0, addr 32'h0000_0010, TRDY# low first DATA cycle, pci_ad_in=1234 -> rsp_valid[0] at accept+3, rsp_rdata=1234, cbe_n=4'hA in ADDR.
- Write req 2, wdata 32'hDEAD_BEEF, TRDY# after 3 waits -> ad_out=DEAD_BEEF with ad_oe=1 through DATA, rsp_valid[2] at accept+6, rsp_err=0.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0, each completes once per 4 transactions.
- req_cmd=3 on req 1 -> no FRAME# assertion, rsp_valid[1] next cycle with rsp_err=1.
- Reset pulled low in DATA -> next cycle frame_n=irdy_n=1, ad_oe=0, no rsp_valid; post-reset request on 0 served normally.
- With PCI_CFG_TIMEOUT_EN, TRDY# never asserted -> rsp_err=1, rsp_rdata=FFFF_FFFF after 16 DATA cycles.

Source files
------------

// File: rtl/pci_cfg_pkg.sv
// Shared command codes, byte-enable encodings and types for the PCI configuration master.
package pci_cfg_pkg;

   localparam logic [1:0] PCI_CFGREAD  = 2'd1;
   localparam logic [1:0] PCI_CFGWRITE = 2'd2;
   localparam logic [3:0] CBE_CFGREAD  = 4'hA;
   localparam logic [3:0] CBE_CFGWRITE = 4'hB;
   localparam logic [3:0] CBE_IDLE     = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_TURN
   } pci_cfg_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  cmd;
      logic [31:0] wdata;
   } pci_cfg_cmd_t;

   function automatic logic is_legal_cmd(input logic [1:0] cmd);
      return (cmd == PCI_CFGREAD) || (cmd == PCI_CFGWRITE);
   endfunction

endpackage

// File: rtl/pci_cfg_rr_arb.sv
// Round-robin arbiter: search starts one past the last winner; the pointer moves only on advance.
module pci_cfg_rr_arb #(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] idx;

   // Scan farthest-first so the nearest requester after the pointer wins.
   always_comb begin
      grant     = '0;
      grant_idx = ptr_q;
      idx       = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= IDX_W'(NUM_REQ - 1);
      end else if (advance) begin
         ptr_q <= grant_idx;
      end
   end

endmodule

// File: rtl/pci_cfg_master.sv
// Single bus master for PCI config cycles: arbitrates requesters, runs ADDR/DATA/TURN, returns status.
// Optional build macro PCI_CFG_TIMEOUT_EN adds a master abort after TIMEOUT_CYCLES DATA cycles.
module pci_cfg_master
   import pci_cfg_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    pci_clk,
   input  logic                    pci_rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [2*NUM_REQ-1:0]    req_cmd,
   input  logic [32*NUM_REQ-1:0]   req_addr,
   input  logic [32*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic                    rsp_err,
   output logic                    pci_frame_n,
   output logic                    pci_irdy_n,
   input  logic                    pci_trdy_n,
   output logic [3:0]              pci_cbe_n,
   output logic [31:0]             pci_ad_out,
   output logic                    pci_ad_oe,
   input  logic [31:0]             pci_ad_in,
   output pci_cfg_state_e          dbg_state
);

   // Handshake: a command transfers when req_valid[g] && req_ready[g] at a rising edge; req_ready
   // is only ever high in IDLE. rsp_valid is a single-cycle pulse with no back-pressure.

   localparam int IDX_W = $clog2(NUM_REQ);

   pci_cfg_state_e   state_q, state_d;
   pci_cfg_cmd_t     cmd_q, cmd_d, sel_cmd;
   logic [IDX_W-1:0] g_q, g_d, grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [31:0]      data_q, data_d;
   logic             err_q, err_d;
   logic             accept, is_write, timeout_hit;

   assign accept    = (state_q == ST_IDLE) && (|req_valid);
   assign is_write  = (cmd_q.cmd == PCI_CFGWRITE);
   assign dbg_state = state_q;

   pci_cfg_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (pci_clk),
      .rst_n     (pci_rst_n),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

`ifdef PCI_CFG_TIMEOUT_EN
   logic [7:0] wait_q;
   always_ff @(posedge pci_clk) begin
      if (!pci_rst_n || state_q != ST_DATA) begin
         wait_q <= '0;
      end else if (pci_trdy_n) begin
         wait_q <= wait_q + 8'd1;
      end
   end
   assign timeout_hit = pci_trdy_n && (wait_q == 8'(TIMEOUT_CYCLES - 1));
`else
   // No master abort in this build: DATA waits for TRDY# indefinitely.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      sel_cmd.addr  = req_addr[int'(grant_idx)*32 +: 32];
      sel_cmd.cmd   = req_cmd[int'(grant_idx)*2 +: 2];
      sel_cmd.wdata = req_wdata[int'(grant_idx)*32 +: 32];
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      g_d     = g_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cmd_d   = sel_cmd;
               g_d     = grant_idx;
               data_d  = '0;
               err_d   = !is_legal_cmd(sel_cmd.cmd);
               // Illegal commands skip the bus and report straight from TURN.
               state_d = is_legal_cmd(sel_cmd.cmd) ? ST_ADDR : ST_TURN;
            end
         end
         ST_ADDR: state_d = ST_DATA;
         ST_DATA: begin
            if (!pci_trdy_n) begin
               data_d  = is_write ? 32'h0 : pci_ad_in;
               err_d   = 1'b0;
               state_d = ST_TURN;
            end else if (timeout_hit) begin
               data_d  = 32'hFFFF_FFFF;
               err_d   = 1'b1;
               state_d = ST_TURN;
            end
         end
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pci_clk) begin
      if (!pci_rst_n) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         g_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         g_q     <= g_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      req_ready   = grant & {NUM_REQ{pci_rst_n && (state_q == ST_IDLE)}};
      rsp_valid   = '0;
      rsp_rdata   = '0;
      rsp_err     = 1'b0;
      pci_frame_n = 1'b1;
      pci_irdy_n  = 1'b1;
      pci_cbe_n   = CBE_IDLE;
      pci_ad_out  = '0;
      pci_ad_oe   = 1'b0;
      case (state_q)
         ST_ADDR: begin
            pci_frame_n = 1'b0;
            pci_cbe_n   = is_write ? CBE_CFGWRITE : CBE_CFGREAD;
            pci_ad_out  = cmd_q.addr;
            pci_ad_oe   = 1'b1;
         end
         ST_DATA: begin
            pci_irdy_n = 1'b0;
            pci_cbe_n  = 4'h0;
            if (is_write) begin
               pci_ad_out = cmd_q.wdata;
               pci_ad_oe  = 1'b1;
            end
         end
         ST_TURN: begin
            rsp_valid[g_q] = 1'b1;
            rsp_rdata      = data_q;
            rsp_err        = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pci_cfg_master.sv
// Bench for pci_cfg_master: directed vector table, corner sequences and a randomized cycle model.
module tb_pci_cfg_master;
   import pci_cfg_pkg::*;

   localparam int NUM_REQ        = 4;
   localparam int TIMEOUT_CYCLES = 16;

   logic                  pci_clk = 1'b0;
   logic                  pci_rst_n;
   logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid;
   logic [2*NUM_REQ-1:0]  req_cmd;
   logic [32*NUM_REQ-1:0] req_addr, req_wdata;
   logic [31:0]           rsp_rdata, pci_ad_out, pci_ad_in;
   logic                  rsp_err, pci_frame_n, pci_irdy_n, pci_trdy_n, pci_ad_oe;
   logic [3:0]            pci_cbe_n;
   pci_cfg_state_e        dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   pci_cfg_master #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .pci_clk(pci_clk), .pci_rst_n(pci_rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .pci_frame_n(pci_frame_n), .pci_irdy_n(pci_irdy_n),
      .pci_trdy_n(pci_trdy_n), .pci_cbe_n(pci_cbe_n), .pci_ad_out(pci_ad_out), .pci_ad_oe(pci_ad_oe),
      .pci_ad_in(pci_ad_in), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 pci_clk = ~pci_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic do_reset();
      @(negedge pci_clk);
      pci_rst_n = 1'b0; req_valid = '0; pci_trdy_n = 1'b1;
      repeat (2) @(negedge pci_clk);
      pci_rst_n = 1'b1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " frame_n"}, 32'(pci_frame_n), 32'h1);
      check({tag, " irdy_n"},  32'(pci_irdy_n),  32'h1);
      check({tag, " cbe_n"},   32'(pci_cbe_n),   32'hF);
      check({tag, " ad_oe"},   32'(pci_ad_oe),   32'h0);
      check({tag, " ad_out"},  pci_ad_out,       32'h0);
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
   endtask

   // ---------------- driver ----------------
   task automatic set_req(input int i, input logic v, input logic [1:0] c,
                          input logic [31:0] a, input logic [31:0] w);
      req_valid[i]          = v;
      req_cmd[2*i +: 2]     = c;
      req_addr[32*i +: 32]  = a;
      req_wdata[32*i +: 32] = w;
   endtask

   typedef struct {
      int          req;
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] ad_in;
      logic [3:0]  exp_cbe;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   // One isolated command: accept, bus phases, response latency and payload.
   task automatic run_vec(input string tag, input vec_t v);
      int d;
      bit seen;
      @(negedge pci_clk);
      set_req(v.req, 1'b1, v.cmd, v.addr, v.wdata);
      #1 check({tag, " accept"}, 32'(req_ready), 32'(1 << v.req));
      d = 0; seen = 0;
      while (!seen && d < 30) begin
         @(negedge pci_clk);
         d++;
         if (d == 1) req_valid[v.req] = 1'b0;
         pci_trdy_n = !(v.exp_cbe != CBE_IDLE && (d == 1 || d == 2 + v.waits));
         pci_ad_in  = pci_trdy_n ? (32'hBAD0_0000 ^ 32'(d)) : v.ad_in;
         #1;
         if (d == 1) begin
            check({tag, " addr frame_n"}, 32'(pci_frame_n), (v.exp_cbe == CBE_IDLE) ? 32'h1 : 32'h0);
            check({tag, " addr cbe_n"}, 32'(pci_cbe_n), 32'(v.exp_cbe));
            if (v.exp_cbe != CBE_IDLE) begin
               check({tag, " addr ad_out"}, pci_ad_out, v.addr);
               check({tag, " addr ad_oe"}, 32'(pci_ad_oe), 32'h1);
            end
         end
         if (v.exp_cbe == CBE_CFGWRITE && d >= 2 && d <= 2 + v.waits) begin
            check({tag, " data ad_out"}, pci_ad_out, v.wdata);
            check({tag, " data ad_oe"}, 32'(pci_ad_oe), 32'h1);
         end
         if (rsp_valid != '0) begin
            seen = 1;
            check({tag, " latency"}, 32'(d), 32'(v.exp_lat));
            check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1 << v.req));
            check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
            check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
         end
      end
      if (!seen) check({tag, " response seen"}, 32'h0, 32'h1);
      pci_trdy_n = 1'b1;
   endtask

   // ---------------- random-phase model state ----------------
   int ptr_m, free_at, t_acc, t_g, t_w, d, g;
   bit busy, t_legal;
   logic [1:0] t_cmd, rc;
   logic [31:0] t_addr, t_wdata, t_rd, exp_rd, e_ad;
   logic [NUM_REQ-1:0] acc_last, e_ready, e_rsp, was_valid;
   logic e_frame, e_irdy, e_oe, e_err;
   logic [3:0] e_cbe;

   vec_t vecs[7];
   vec_t post_v;
   int n_g, n_r;

   initial begin
      pci_rst_n = 1'b0; req_valid = '1; req_cmd = '0; req_addr = '0; req_wdata = '0;
      pci_trdy_n = 1'b1; pci_ad_in = '0;
      for (int i = 0; i < NUM_REQ; i++) req_cmd[2*i +: 2] = PCI_CFGREAD;

      // Reset state, with requests pending so req_ready must stay low.
      repeat (2) @(negedge pci_clk);
      #1;
      check("reset req_ready", 32'(req_ready), 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset rsp_err", 32'(rsp_err), 32'h0);
      check("reset state", 32'(dbg_state), 32'(ST_IDLE));
      check_idle("reset");
      req_valid = '0;
      pci_rst_n = 1'b1;

      // Directed table.
      vecs[0] = '{req:0, cmd:PCI_CFGREAD,  addr:32'h0000_0010, wdata:32'h0,         waits:0,
                  ad_in:32'd1234,       exp_cbe:4'hA, exp_rdata:32'd1234,       exp_err:1'b0, exp_lat:3};
      vecs[1] = '{req:2, cmd:PCI_CFGWRITE, addr:32'h0000_0104, wdata:32'hDEAD_BEEF, waits:3,
                  ad_in:32'h0000_0055,  exp_cbe:4'hB, exp_rdata:32'h0,          exp_err:1'b0, exp_lat:6};
      vecs[2] = '{req:1, cmd:2'd3,         addr:32'h0000_0020, wdata:32'h0,         waits:0,
                  ad_in:32'h0,          exp_cbe:4'hF, exp_rdata:32'h0,          exp_err:1'b1, exp_lat:1};
      vecs[3] = '{req:3, cmd:PCI_CFGREAD,  addr:32'h0800_0000, wdata:32'h0,         waits:1,
                  ad_in:32'hA5A5_0F0F,  exp_cbe:4'hA, exp_rdata:32'hA5A5_0F0F,  exp_err:1'b0, exp_lat:4};
      vecs[4] = '{req:0, cmd:2'd0,         addr:32'h0000_0030, wdata:32'h1,         waits:0,
                  ad_in:32'h0,          exp_cbe:4'hF, exp_rdata:32'h0,          exp_err:1'b1, exp_lat:1};
      vecs[5] = '{req:1, cmd:PCI_CFGWRITE, addr:32'h0000_0044, wdata:32'h0123_4567, waits:0,
                  ad_in:32'hFFFF_0000,  exp_cbe:4'hB, exp_rdata:32'h0,          exp_err:1'b0, exp_lat:3};
      vecs[6] = '{req:3, cmd:PCI_CFGREAD,  addr:32'h00FF_FFFC, wdata:32'h0,         waits:2,
                  ad_in:32'hFFFF_FFFF,  exp_cbe:4'hA, exp_rdata:32'hFFFF_FFFF,  exp_err:1'b0, exp_lat:5};
      for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // All requesters held valid: grants 0,1,2,3,0 and completions 0,1,2,3.
      do_reset();
      @(negedge pci_clk);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, PCI_CFGREAD, 32'h100 + 32'(i*4), 32'h0);
      pci_trdy_n = 1'b0;
      n_g = 0; n_r = 0;
      for (int c = 0; c < 40 && n_g < 5; c++) begin
         if (c > 0) @(negedge pci_clk);
         #1;
         if (req_ready != '0) begin
            check("rr grant", 32'(req_ready), 32'(1 << (n_g % NUM_REQ)));
            n_g++;
         end
         if (rsp_valid != '0 && n_r < NUM_REQ) begin
            check("rr complete", 32'(rsp_valid), 32'(1 << n_r));
            n_r++;
         end
      end
      check("rr grant count", 32'(n_g), 32'd5);
      check("rr complete count", 32'(n_r), 32'(NUM_REQ));

      // Reset during the DATA phase of the fifth transaction.
      @(negedge pci_clk);
      req_valid = '0; pci_trdy_n = 1'b1;
      @(negedge pci_clk);
      #1 check("mid-reset in data irdy_n", 32'(pci_irdy_n), 32'h0);
      pci_rst_n = 1'b0; pci_trdy_n = 1'b0;
      @(negedge pci_clk);
      #1 check_idle("mid-reset");
      check("mid-reset state", 32'(dbg_state), 32'(ST_IDLE));
      pci_rst_n = 1'b1; pci_trdy_n = 1'b1;
      repeat (3) begin
         @(negedge pci_clk);
         #1 check("post-reset no rsp", 32'(rsp_valid), 32'h0);
      end
      post_v = '{req:0, cmd:PCI_CFGREAD, addr:32'h0000_0008, wdata:32'h0, waits:0,
                 ad_in:32'h1357_9BDF, exp_cbe:4'hA, exp_rdata:32'h1357_9BDF, exp_err:1'b0, exp_lat:3};
      run_vec("post-reset", post_v);

`ifdef PCI_CFG_TIMEOUT_EN
      post_v = '{req:1, cmd:PCI_CFGREAD, addr:32'h0000_0040, wdata:32'h0, waits:100,
                 ad_in:32'h0, exp_cbe:4'hA, exp_rdata:32'hFFFF_FFFF, exp_err:1'b1,
                 exp_lat:2 + TIMEOUT_CYCLES};
      run_vec("timeout", post_v);
`endif

      // Randomized traffic against a cycle-timeline model of the protocol rules.
      do_reset();
      ptr_m = NUM_REQ - 1; free_at = 0; busy = 0; t_acc = 0; acc_last = '0;
      t_g = 0; t_w = 0; t_legal = 0; t_cmd = '0; t_addr = '0; t_wdata = '0; t_rd = '0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         @(negedge pci_clk);
         was_valid = req_valid;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_last[i] || (req_valid[i] && $urandom_range(0, 15) == 0)) req_valid[i] = 1'b0;
            if (!was_valid[i] && cyc < 1140 && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 7) == 0) rc = $urandom_range(0, 1) ? 2'd3 : 2'd0;
               else rc = $urandom_range(0, 1) ? PCI_CFGREAD : PCI_CFGWRITE;
               set_req(i, 1'b1, rc, $urandom, $urandom);
            end
         end
         acc_last = '0;
         e_ready  = '0;
         if (cyc >= free_at && req_valid != '0) begin
            g = (ptr_m + 1) % NUM_REQ;
            while (!req_valid[g]) g = (g + 1) % NUM_REQ;
            e_ready[g] = 1'b1; acc_last[g] = 1'b1; ptr_m = g;
            t_acc = cyc; t_g = g; busy = 1;
            t_cmd = req_cmd[2*g +: 2]; t_addr = req_addr[32*g +: 32]; t_wdata = req_wdata[32*g +: 32];
            t_legal = (t_cmd == PCI_CFGREAD) || (t_cmd == PCI_CFGWRITE);
            t_w = $urandom_range(0, 3); t_rd = $urandom;
            free_at = t_legal ? cyc + 4 + t_w : cyc + 2;
            exp_q.push_back((t_legal && t_cmd == PCI_CFGREAD) ? t_rd : 32'h0);
         end
         d = cyc - t_acc;
         e_frame = 1'b1; e_irdy = 1'b1; e_cbe = CBE_IDLE; e_oe = 1'b0; e_ad = '0;
         e_rsp = '0; e_err = 1'b0;
         pci_trdy_n = 1'($urandom_range(0, 1));
         pci_ad_in  = $urandom;
         if (busy && t_legal) begin
            if (d == 1) begin
               e_frame = 1'b0; e_oe = 1'b1; e_ad = t_addr;
               e_cbe = (t_cmd == PCI_CFGWRITE) ? CBE_CFGWRITE : CBE_CFGREAD;
            end else if (d >= 2 && d <= 2 + t_w) begin
               e_irdy = 1'b0; e_cbe = 4'h0;
               if (t_cmd == PCI_CFGWRITE) begin e_oe = 1'b1; e_ad = t_wdata; end
               pci_trdy_n = (d != 2 + t_w);
               if (d == 2 + t_w) pci_ad_in = t_rd;
            end else if (d == 3 + t_w) begin
               e_rsp[t_g] = 1'b1;
            end
         end else if (busy && !t_legal && d == 1) begin
            e_rsp[t_g] = 1'b1; e_err = 1'b1;
         end
         #1;
         check("rnd req_ready", 32'(req_ready), 32'(e_ready));
         check("rnd frame_n", 32'(pci_frame_n), 32'(e_frame));
         check("rnd irdy_n", 32'(pci_irdy_n), 32'(e_irdy));
         check("rnd cbe_n", 32'(pci_cbe_n), 32'(e_cbe));
         check("rnd ad_oe", 32'(pci_ad_oe), 32'(e_oe));
         if (e_oe) check("rnd ad_out", pci_ad_out, e_ad);
         check("rnd rsp_valid", 32'(rsp_valid), 32'(e_rsp));
         if (e_rsp != '0) begin
            exp_rd = exp_q.pop_front();
            check("rnd rsp_rdata", rsp_rdata, exp_rd);
            check("rnd rsp_err", 32'(rsp_err), 32'(e_err));
         end
      end
      check("rnd drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
